sfx_scheduler: RTL and testbench
================================

// Module: sfx_scheduler
// PURPOSE
//  Sequences the tone generator: arbitrates background music, jump and game-over sound
//  sources and emits the 7-bit note code consumed by the note-to-period lookup.
//  Owns the step tick; the PWM datapath only renders whatever code it is given.
//  Priority: game-over > jump > music > silence.
// PARAMETERS
//  TICK_DIV   50000  clk cycles per sequencer step (>=2)
//  MUSIC_LEN  26     music steps per loop; step s emits code 2*s
//  JUMP_LEN   3      steps the jump effect lasts (>=1)
// PORTS
//  clk        in   1  system clock
//  reset      in   1  synchronous, active-high reset
//  enable     in   1  0 = freeze sequencer, output silence
//  music_en   in   1  level; background loop allowed
//  jump_req   in   1  1-cycle pulse; start/retrigger jump effect
//  over_req   in   1  1-cycle pulse; enter game-over tone
//  over_clr   in   1  1-cycle pulse; leave game-over
//  note_code  out  7  registered note code to lookup (127 = off)
//  note_stb   out  1  1-cycle pulse whenever note_code is (re)loaded
//  src        out  2  active source: 0 idle, 1 music, 2 jump, 3 over
//  busy       out  1  src != 0
// BEHAVIOUR
//  Reset: state IDLE, step=0, jump_cnt=0, divider=0, note_code=127, note_stb=0, src=0, busy=0.
//  Divider: counts 0..TICK_DIV-1 while enable; tick=1 in cycle count==TICK_DIV-1, then wraps.
//   Sync restart input forces count=0 (used on every SFX entry/retrigger).
//  All outputs registered; FSM change visible one cycle after triggering input/tick.
//  enable=0: FSM, step, jump_cnt, divider hold; requests ignored; note_code=127; no stb.
//   enable rising: next cycle restores the held state's note_code and pulses note_stb.
//  States / transitions (evaluated only when enable=1; first matching rule wins):
//   any not OVER, over_req        -> OVER, code 54, restart divider
//   OVER: over_clr & !over_req    -> IDLE, code 127, step=0; all else (incl. jump) ignored
//   IDLE/MUSIC/JUMP, jump_req     -> JUMP, code 53, jump_cnt=0, restart divider (retrigger)
//   JUMP, tick, jump_cnt==JUMP_LEN-1 -> MUSIC (code 2*step, step NOT advanced) if music_en
//                                   else IDLE (127); otherwise tick increments jump_cnt
//   IDLE, music_en & tick         -> MUSIC, code 2*step
//   MUSIC, !music_en              -> IDLE next cycle, step retained
//   MUSIC, tick                   -> step = (step==MUSIC_LEN-1) ? 0 : step+1; code 2*step_new
//  Music step frozen while JUMP/OVER (preempted song resumes at same step).
//  Same-cycle over_req+over_clr: over_req wins, stays OVER, no reload.
//  note_stb: high exactly on cycles note_code loaded by a transition or step advance,
//   even if value unchanged; never in reset cycle.
//  Widths: step $clog2(MUSIC_LEN), jump_cnt $clog2(JUMP_LEN+1), divider $clog2(TICK_DIV);
//   code 2*step fits 7 bits for MUSIC_LEN<=53 (elaboration assert).
// STRUCTURE
//  Package sound_pkg: NOTE_JUMP=7'd53, NOTE_OVER=7'd54, NOTE_OFF=7'd127,
//   typedef enum logic[1:0] {SRC_IDLE,SRC_MUSIC,SRC_JUMP,SRC_OVER} src_t (also FSM state).
//  Sub-module tick_div (count, restart, enable -> tick); FSM + step/jump counters inline.
// TESTING (bench params TICK_DIV=4, MUSIC_LEN=4, JUMP_LEN=2)
//  1 reset high 3 cycles, then music_en=1 -> code 127 until first tick, then 0,2,4,6,0
//    every 4 cycles, note_stb each change, src=1.
//  2 jump_req at step 2 (code 4) -> next cycle code 53,src=2; 8 cycles later code 4 again
//    (same step), then 6 after 4 more cycles.
//  3 jump_req again 3 cycles into JUMP -> code stays 53, stb pulses, JUMP lasts 8 cycles
//    from retrigger.
//  4 over_req+jump_req same cycle -> code 54,src=3; later jump_req ignored; over_clr ->
//    code 127, src=0; music restarts at code 0.
//  5 enable=0 for 10 cycles mid-MUSIC at code 2 -> code 127, no stb, requests ignored;
//    enable=1 -> code 2 + stb, next advance after remaining divider count.
//  6 reset asserted mid-JUMP -> next cycle all outputs at reset values, step=0.

Source files
------------

// File: rtl/sound_pkg.sv
// Shared constants and types for the sound-effect sequencer.
// The source enum doubles as the scheduler FSM state, so the reported
// source and the internal state can never disagree.
package sound_pkg;

  localparam logic [6:0] NOTE_JUMP = 7'd53;
  localparam logic [6:0] NOTE_OVER = 7'd54;
  localparam logic [6:0] NOTE_OFF  = 7'd127;

  typedef enum logic [1:0] {
    SRC_IDLE  = 2'd0,
    SRC_MUSIC = 2'd1,
    SRC_JUMP  = 2'd2,
    SRC_OVER  = 2'd3
  } src_t;

endpackage

// File: rtl/tick_div.sv
// Step-tick divider: counts 0..TICK_DIV-1 while enabled and flags the last
// count as the sequencer step tick. A synchronous restart lets each new
// sound effect begin with a full-length first step.
module tick_div #(
  parameter int TICK_DIV = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic restart,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [CW-1:0] count;

  if (TICK_DIV < 2) begin : g_bad_tick_div
    $error("TICK_DIV must be at least 2");
  end

  assign tick = enable && (count == CNT_LAST);

  // Free-running step counter; restart has priority and a disabled divider holds.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (restart) begin
      count <= '0;
    end else if (enable) begin
      count <= (count == CNT_LAST) ? '0 : count + CNT_ONE;
    end
  end

endmodule

// File: rtl/sfx_scheduler.sv
// Tone-generator scheduler: arbitrates game-over, jump and background music
// (in that priority) and emits a registered 7-bit note code plus a load strobe.
// The music step is frozen while an effect plays so the song resumes in place.
module sfx_scheduler
  import sound_pkg::*;
#(
  parameter int TICK_DIV  = 50000,
  parameter int MUSIC_LEN = 26,
  parameter int JUMP_LEN  = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       music_en,
  input  logic       jump_req,
  input  logic       over_req,
  input  logic       over_clr,
  output logic [6:0] note_code,
  output logic       note_stb,
  output logic [1:0] src,
  output logic       busy
);

  localparam int SW = (MUSIC_LEN > 1) ? $clog2(MUSIC_LEN) : 1;
  localparam int JW = $clog2(JUMP_LEN + 1);
  localparam logic [SW-1:0] STEP_LAST = SW'(MUSIC_LEN - 1);
  localparam logic [SW-1:0] STEP_ONE  = SW'(1);
  localparam logic [JW-1:0] JUMP_LAST = JW'(JUMP_LEN - 1);
  localparam logic [JW-1:0] JUMP_ONE  = JW'(1);

  if (MUSIC_LEN < 2 || MUSIC_LEN > 53) begin : g_bad_music_len
    $error("MUSIC_LEN must be in 2..53 so that 2*step fits the 7-bit note code");
  end

  if (JUMP_LEN < 1) begin : g_bad_jump_len
    $error("JUMP_LEN must be at least 1");
  end

  src_t          state;
  logic [SW-1:0] step;
  logic [SW-1:0] step_next;
  logic [JW-1:0] jump_cnt;
  logic          enable_q;
  logic          tick;
  logic          restart;

  // Music step s plays note code 2*s.
  function automatic logic [6:0] music_code(input logic [SW-1:0] s);
    return 7'({s, 1'b0});
  endfunction

  // Code that belongs to a state when nothing else is changing it.
  function automatic logic [6:0] held_code(input src_t st, input logic [SW-1:0] s);
    logic [6:0] code;
    code = NOTE_OFF;
    case (st)
      SRC_MUSIC: code = music_code(s);
      SRC_JUMP:  code = NOTE_JUMP;
      SRC_OVER:  code = NOTE_OVER;
      default:   code = NOTE_OFF;
    endcase
    return code;
  endfunction

  assign step_next = (step == STEP_LAST) ? '0 : step + STEP_ONE;

  // Entering game-over or (re)starting a jump realigns the step tick.
  assign restart = enable && (state != SRC_OVER) && (over_req || jump_req);

  assign src = state;

  tick_div #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_div (
    .clk     (clk),
    .reset   (reset),
    .enable  (enable),
    .restart (restart),
    .tick    (tick)
  );

  // Source FSM with step/jump counters; every output is loaded here so all are registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= SRC_IDLE;
      step      <= '0;
      jump_cnt  <= '0;
      note_code <= NOTE_OFF;
      note_stb  <= 1'b0;
      busy      <= 1'b0;
      enable_q  <= 1'b1;
    end else begin
      enable_q <= enable;
      note_stb <= 1'b0;
      if (!enable) begin
        note_code <= NOTE_OFF;
      end else begin
        if (!enable_q) begin
          note_code <= held_code(state, step);
          note_stb  <= 1'b1;
        end
        if (state != SRC_OVER && over_req) begin
          state     <= SRC_OVER;
          busy      <= 1'b1;
          note_code <= NOTE_OVER;
          note_stb  <= 1'b1;
        end else if (state == SRC_OVER) begin
          if (over_clr && !over_req) begin
            state     <= SRC_IDLE;
            busy      <= 1'b0;
            step      <= '0;
            note_code <= NOTE_OFF;
            note_stb  <= 1'b1;
          end
        end else if (jump_req) begin
          state     <= SRC_JUMP;
          busy      <= 1'b1;
          jump_cnt  <= '0;
          note_code <= NOTE_JUMP;
          note_stb  <= 1'b1;
        end else begin
          case (state)
            SRC_JUMP: begin
              if (tick) begin
                if (jump_cnt == JUMP_LAST) begin
                  note_stb <= 1'b1;
                  if (music_en) begin
                    state     <= SRC_MUSIC;
                    busy      <= 1'b1;
                    note_code <= music_code(step);
                  end else begin
                    state     <= SRC_IDLE;
                    busy      <= 1'b0;
                    note_code <= NOTE_OFF;
                  end
                end else begin
                  jump_cnt <= jump_cnt + JUMP_ONE;
                end
              end
            end
            SRC_MUSIC: begin
              if (!music_en) begin
                state     <= SRC_IDLE;
                busy      <= 1'b0;
                note_code <= NOTE_OFF;
                note_stb  <= 1'b1;
              end else if (tick) begin
                step      <= step_next;
                note_code <= music_code(step_next);
                note_stb  <= 1'b1;
              end
            end
            SRC_IDLE: begin
              if (music_en && tick) begin
                state     <= SRC_MUSIC;
                busy      <= 1'b1;
                note_code <= music_code(step);
                note_stb  <= 1'b1;
              end
            end
            default: begin
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_sfx_scheduler.sv
// Directed bench for sfx_scheduler with TICK_DIV=4, MUSIC_LEN=4, JUMP_LEN=2.
// Inputs change just after a falling edge and outputs are sampled on the
// falling edge after the rising edge that consumed them.
module tb_sfx_scheduler;

  localparam int TICK_DIV  = 4;
  localparam int MUSIC_LEN = 4;
  localparam int JUMP_LEN  = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic       music_en;
  logic       jump_req;
  logic       over_req;
  logic       over_clr;
  logic [6:0] note_code;
  logic       note_stb;
  logic [1:0] src;
  logic       busy;

  int errors = 0;
  int checks = 0;

  sfx_scheduler #(
    .TICK_DIV  (TICK_DIV),
    .MUSIC_LEN (MUSIC_LEN),
    .JUMP_LEN  (JUMP_LEN)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .music_en  (music_en),
    .jump_req  (jump_req),
    .over_req  (over_req),
    .over_clr  (over_clr),
    .note_code (note_code),
    .note_stb  (note_stb),
    .src       (src),
    .busy      (busy)
  );

  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports any mismatch.
  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Drive one cycle of request pulses, then clear them at the next falling edge.
  task automatic applyStimulus(input logic jr, input logic orq, input logic oc);
    jump_req = jr;
    over_req = orq;
    over_clr = oc;
    @(negedge clk);
    jump_req = 1'b0;
    over_req = 1'b0;
    over_clr = 1'b0;
  endtask

  // Check all four outputs; busy is expected whenever the source is not idle.
  task automatic checkNote(input string tag, input int code, input int stb, input int s);
    checkOutput({tag, ".code"}, int'(note_code), code);
    checkOutput({tag, ".stb"},  int'(note_stb),  stb);
    checkOutput({tag, ".src"},  int'(src),       s);
    checkOutput({tag, ".busy"}, int'(busy),      (s != 0) ? 1 : 0);
  endtask

  // Idle for n cycles expecting a steady code with no strobe.
  task automatic holdNote(input string tag, input int n, input int code, input int s);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkNote(tag, code, 0, s);
    end
  endtask

  // Directed scenario sequence; expected codes are worked out by hand from the tick timing.
  initial begin
    int seq_codes [6];
    int prev_code;
    seq_codes = '{2, 4, 6, 0, 2, 4};

    reset    = 1'b1;
    enable   = 1'b1;
    music_en = 1'b0;
    jump_req = 1'b0;
    over_req = 1'b0;
    over_clr = 1'b0;
    @(negedge clk);

    repeat (3) applyStimulus(1'b0, 1'b0, 1'b0);
    checkNote("reset", 127, 0, 0);

    // Music loop: silence until the first tick, then a new step every 4 cycles.
    reset    = 1'b0;
    music_en = 1'b1;
    holdNote("t1.wait", 3, 127, 0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkNote("t1.first", 0, 1, 1);
    prev_code = 0;
    for (int k = 0; k < 6; k++) begin
      holdNote("t1.hold", 3, prev_code, 1);
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkNote("t1.step", seq_codes[k], 1, 1);
      prev_code = seq_codes[k];
    end

    // Jump at step 2 lasts 8 cycles and resumes the same step.
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkNote("t2.enter", 53, 1, 2);
    holdNote("t2.jump", 7, 53, 2);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkNote("t2.resume", 4, 1, 1);
    holdNote("t2.hold", 3, 4, 1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkNote("t2.next", 6, 1, 1);

    // Retrigger 3 cycles into the jump, landing on the tick cycle.
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkNote("t3.enter", 53, 1, 2);
    holdNote("t3.jump", 3, 53, 2);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkNote("t3.retrig", 53, 1, 2);
    holdNote("t3.hold", 7, 53, 2);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkNote("t3.resume", 6, 1, 1);

    // Game-over beats a same-cycle jump, ignores jumps, and over_req beats over_clr.
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkNote("t4.over", 54, 1, 3);
    holdNote("t4.hold", 3, 54, 3);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkNote("t4.jumpign", 54, 0, 3);
    holdNote("t4.hold2", 1, 54, 3);
    applyStimulus(1'b0, 1'b1, 1'b1);
    checkNote("t4.both", 54, 0, 3);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkNote("t4.clr", 127, 1, 0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkNote("t4.restart", 0, 1, 1);

    // Freeze mid-step at code 2; requests while frozen must not act.
    holdNote("t5.pre", 3, 0, 1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkNote("t5.code2", 2, 1, 1);
    holdNote("t5.pre2", 1, 2, 1);
    enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(i == 2, i == 5, 1'b0);
      checkNote("t5.off", 127, 0, 1);
    end
    enable = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkNote("t5.restore", 2, 1, 1);
    holdNote("t5.remain", 1, 2, 1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkNote("t5.adv", 4, 1, 1);

    // Reset during a jump clears everything, including the music step.
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkNote("t6.jump", 53, 1, 2);
    holdNote("t6.hold", 1, 53, 2);
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkNote("t6.reset", 127, 0, 0);
    reset = 1'b0;
    holdNote("t6.wait", 3, 127, 0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkNote("t6.step0", 0, 1, 1);

    // Dropping music_en goes idle at once but keeps the step for later.
    holdNote("t7.pre", 3, 0, 1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkNote("t7.code2", 2, 1, 1);
    music_en = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkNote("t7.idle", 127, 1, 0);
    music_en = 1'b1;
    holdNote("t7.wait", 2, 127, 0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkNote("t7.keep", 2, 1, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
